// File: rtl/serial_mult_sc.v


// File: rtl/serial_mult_sc.sv
// ---------------------------------------------------------------------------
// serial_mult_sc
//   Radix-2 shift-add multiplier for RISC-V MUL / MULH / MULHSU / MULHU.
//   One product bit is retired per cycle, so a normal operation takes WIDTH
//   iterations regardless of the operand values. A zero-operand shortcut
//   exists, but it is taken only when both operand labels are clear. Secret
//   operands therefore always see the full, data-independent latency.
//
//   Handshakes (shared with the serial divider):
//     Issue:  an operation is taken on a rising edge where the block is IDLE,
//             in_vld_i=1 and flush_i=0. in_rdy_o is high only in IDLE while
//             in_vld_i is low.
//     Result: res_o/id_o/res_label_o are valid while out_vld_o=1. They stay
//             stable until a rising edge with out_rdy_i=1 consumes them.
//     flush_i overrides both: it masks in_rdy_o and out_vld_o. The block
//             then returns to IDLE on the next edge without loading anything.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   id_i / id_o           transaction ID in / ID of the current result
//   op_a_i, op_b_i        multiplicand (rs1), multiplier (rs2)
//   opcode_i              0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
//   in_vld_i, in_rdy_o    issue handshake
//   flush_i               abandon the current operation
//   out_vld_o, out_rdy_i  result handshake
//   res_o                 selected half of the signed-corrected product
//   op_a_label_i,
//   op_b_label_i          security labels of the operands (1 = secret)
//   res_label_o           label of res_o (OR of the operand labels)
//   state_o               current FSM state (0 IDLE, 1 MULT, 2 FINISH)
// ---------------------------------------------------------------------------
module serial_mult_sc #(
   parameter int WIDTH         = 64,
   parameter int TRANS_ID_BITS = 3
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [TRANS_ID_BITS-1:0] id_i,
   input  logic [WIDTH-1:0]         op_a_i,
   input  logic [WIDTH-1:0]         op_b_i,
   input  logic [1:0]               opcode_i,
   input  logic                     in_vld_i,
   output logic                     in_rdy_o,
   input  logic                     flush_i,
   output logic                     out_vld_o,
   input  logic                     out_rdy_i,
   output logic [TRANS_ID_BITS-1:0] id_o,
   output logic [WIDTH-1:0]         res_o,
   input  logic                     op_a_label_i,
   input  logic                     op_b_label_i,
   output logic                     res_label_o,
   output logic [1:0]               state_o
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MULT   = 2'd1,
      FINISH = 2'd2
   } state_e;

   state_e                   state_q;
   logic [TRANS_ID_BITS-1:0] id_q;
   logic                     a_label_q;
   logic                     b_label_q;
   logic [1:0]               opcode_q;
   logic                     neg_q;
   logic                     fast_zero_q;
   logic [WIDTH-1:0]         mcand_q;
   logic [WIDTH-1:0]         mplier_q;
   logic [2*WIDTH-1:0]       prod_q;
   logic [CNT_W-1:0]         cnt_q;

   // Operand preparation for the load edge.
   logic                     sign_a;
   logic                     sign_b;
   logic [WIDTH-1:0]         abs_a;
   logic [WIDTH-1:0]         abs_b;
   logic                     accept;

   // Only the operands that this opcode treats as signed contribute a sign.
   assign sign_a = op_a_i[WIDTH-1] & ((opcode_i == 2'd1) | (opcode_i == 2'd2));
   assign sign_b = op_b_i[WIDTH-1] & (opcode_i == 2'd1);
   // Unsigned negation maps the most negative value onto 2^(WIDTH-1), which
   // still fits in WIDTH unsigned bits.
   assign abs_a  = sign_a ? (~op_a_i + WIDTH'(1)) : op_a_i;
   assign abs_b  = sign_b ? (~op_b_i + WIDTH'(1)) : op_b_i;
   assign accept = (state_q == IDLE) & in_vld_i & ~flush_i;

   // One shift-add step. The sum keeps the carry so the shifted upper half
   // stays exact.
   logic [WIDTH:0] step_sum;
   assign step_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                   + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         id_q        <= '0;
         a_label_q   <= 1'b0;
         b_label_q   <= 1'b0;
         opcode_q    <= 2'd0;
         neg_q       <= 1'b0;
         fast_zero_q <= 1'b0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         prod_q      <= '0;
         cnt_q       <= '0;
      end else if (flush_i) begin
         // Datapath contents are left stale. Nothing reads them until the
         // next load overwrites them.
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  id_q        <= id_i;
                  a_label_q   <= op_a_label_i;
                  b_label_q   <= op_b_label_i;
                  opcode_q    <= opcode_i;
                  neg_q       <= sign_a ^ sign_b;
                  mcand_q     <= abs_a;
                  mplier_q    <= abs_b;
                  prod_q      <= '0;
                  cnt_q       <= CNT_W'(WIDTH-1);
                  // The shortcut is permitted only for public operands.
                  fast_zero_q <= ((abs_a == '0) | (abs_b == '0))
                               & ~(op_a_label_i | op_b_label_i);
                  state_q     <= MULT;
               end
            end
            MULT: begin
               if (fast_zero_q) begin
                  // The result (zero) is already presented in this cycle.
                  state_q <= out_rdy_i ? IDLE : FINISH;
               end else begin
                  prod_q   <= {step_sum, prod_q[WIDTH-1:1]};
                  mplier_q <= mplier_q >> 1;
                  cnt_q    <= cnt_q - CNT_W'(1);
                  if (cnt_q == '0) begin
                     state_q <= FINISH;
                  end
               end
            end
            FINISH: begin
               if (out_rdy_i) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Result formation from registered state only.
   logic [2*WIDTH-1:0] prod_signed;
   assign prod_signed = neg_q ? (~prod_q + (2*WIDTH)'(1)) : prod_q;

   assign res_o       = (opcode_q == 2'd0) ? prod_signed[WIDTH-1:0]
                                           : prod_signed[2*WIDTH-1:WIDTH];
   assign id_o        = id_q;
   assign res_label_o = a_label_q | b_label_q;
   assign in_rdy_o    = (state_q == IDLE) & ~in_vld_i & ~flush_i;
   assign out_vld_o   = ~flush_i & ((state_q == FINISH)
                                  | ((state_q == MULT) & fast_zero_q));
   assign state_o     = state_q;

endmodule

// File: tb/tb_serial_mult_sc.sv
// ---------------------------------------------------------------------------
// tb_serial_mult_sc
//   Bench for serial_mult_sc. Expected products come from a 2*W-bit
//   arithmetic reference model. Latencies are counted in clock edges after
//   the acceptance edge T0. Inputs change and outputs are sampled on the
//   falling edge of the clock.
// ---------------------------------------------------------------------------
module tb_serial_mult_sc;

   localparam int W   = 64;
   localparam int IDW = 3;
   localparam int LAT = W + 1;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [IDW-1:0] id_in;
   logic [W-1:0]   op_a;
   logic [W-1:0]   op_b;
   logic [1:0]     opcode;
   logic           in_vld;
   logic           in_rdy;
   logic           flush;
   logic           out_vld;
   logic           out_rdy;
   logic [IDW-1:0] id_out;
   logic [W-1:0]   res;
   logic           la;
   logic           lb;
   logic           res_label;
   logic [1:0]     state;

   int n_tests = 0;
   int n_fail  = 0;

   serial_mult_sc #(.WIDTH(W), .TRANS_ID_BITS(IDW)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .id_i         (id_in),
      .op_a_i       (op_a),
      .op_b_i       (op_b),
      .opcode_i     (opcode),
      .in_vld_i     (in_vld),
      .in_rdy_o     (in_rdy),
      .flush_i      (flush),
      .out_vld_o    (out_vld),
      .out_rdy_i    (out_rdy),
      .id_o         (id_out),
      .res_o        (res),
      .op_a_label_i (la),
      .op_b_label_i (lb),
      .res_label_o  (res_label),
      .state_o      (state)
   );

   always #5 clk = ~clk;

   // Reference model: extend each operand to 2*W bits according to its
   // signedness, multiply modulo 2^(2W), and select the requested half.
   function automatic logic [W-1:0] ref_mul(input logic [1:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      logic [2*W-1:0] ae;
      logic [2*W-1:0] be;
      logic [2*W-1:0] p;
      ae = (op == 2'd1 || op == 2'd2) ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
      be = (op == 2'd1) ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
      p  = ae * be;
      return (op == 2'd0) ? p[W-1:0] : p[2*W-1:W];
   endfunction

   function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic l_a, input logic l_b);
      return ((a == '0 || b == '0) && !(l_a || l_b)) ? 1 : LAT;
   endfunction

   // ---------------- driver tasks ----------------
   // Presents one operation and returns at the falling edge of cycle T0+1.
   task automatic issue(input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic l_a,
                        input logic l_b, input logic [IDW-1:0] id);
      @(negedge clk);
      opcode = op; op_a = a; op_b = b; la = l_a; lb = l_b; id_in = id;
      in_vld = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_vld = 1'b0;
   endtask

   // Counts cycles after T0 until out_vld is seen, bounded.
   task automatic wait_result(output int lat);
      lat = 1;
      while (!out_vld && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic consume();
      out_rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_rdy = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if (in_rdy !== 1'b1 || out_vld !== 1'b0 || id_out !== '0 ||
          res !== '0 || res_label !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: rdy=%b vld=%b id=%0d res=%h lbl=%b, want 1 0 0 0 0",
                  in_rdy, out_vld, id_out, res, res_label);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (in_rdy !== 1'b1 || out_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: rdy=%b vld=%b, want 1 0", in_rdy, out_vld);
      end
   endtask

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
   } vec_t;

   task automatic test_directed();
      vec_t tbl[7];
      int   lat;
      tbl[0] = '{2'd0, 64'd3, 64'd5, 64'd15};
      tbl[1] = '{2'd1, {W{1'b1}}, {W{1'b1}}, 64'd0};
      tbl[2] = '{2'd2, {W{1'b1}}, {W{1'b1}}, {W{1'b1}}};
      tbl[3] = '{2'd3, {W{1'b1}}, {W{1'b1}}, 64'hFFFF_FFFF_FFFF_FFFE};
      tbl[4] = '{2'd0, {W{1'b1}}, {W{1'b1}}, 64'd1};
      tbl[5] = '{2'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                 64'h4000_0000_0000_0000};
      tbl[6] = '{2'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0};
      for (int i = 0; i < 7; i++) begin
         issue(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, 1'b0, IDW'(i + 1));
         wait_result(lat);
         n_tests++;
         if (lat != LAT || res !== tbl[i].exp || id_out !== IDW'(i + 1) ||
             res_label !== 1'b0) begin
            n_fail++;
            $display("FAIL directed[%0d]: lat=%0d res=%h id=%0d lbl=%b, want lat=%0d res=%h id=%0d lbl=0",
                     i, lat, res, id_out, res_label, LAT, tbl[i].exp, i + 1);
         end
         consume();
      end
   endtask

   task automatic test_zero();
      int lat;
      issue(2'd0, '0, 64'd7, 1'b0, 1'b0, 3'd2);
      wait_result(lat);
      n_tests++;
      if (lat != 1 || res !== '0 || id_out !== 3'd2 || res_label !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_public: lat=%0d res=%h id=%0d lbl=%b, want lat=1 res=0 id=2 lbl=0",
                  lat, res, id_out, res_label);
      end
      consume();
      issue(2'd0, '0, 64'd7, 1'b1, 1'b0, 3'd3);
      wait_result(lat);
      n_tests++;
      if (lat != LAT || res !== '0 || id_out !== 3'd3 || res_label !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_secret: lat=%0d res=%h id=%0d lbl=%b, want lat=%0d res=0 id=3 lbl=1",
                  lat, res, id_out, res_label, LAT);
      end
      consume();
   endtask

   task automatic test_random();
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         l_a;
      logic         l_b;
      logic [IDW-1:0] id;
      int           lat;
      int           sel;
      for (int i = 0; i < 24; i++) begin
         op  = 2'($urandom_range(0, 3));
         a   = {$urandom, $urandom};
         b   = {$urandom, $urandom};
         l_a = 1'($urandom_range(0, 1));
         l_b = 1'($urandom_range(0, 1));
         id  = IDW'($urandom_range(0, 7));
         sel = $urandom_range(0, 7);
         case (sel)
            0: a = '0;
            1: b = '0;
            2: a = {1'b1, {(W-1){1'b0}}};
            3: b = {W{1'b1}};
            default: ;
         endcase
         issue(op, a, b, l_a, l_b, id);
         wait_result(lat);
         n_tests++;
         if (lat != ref_lat(a, b, l_a, l_b) || res !== ref_mul(op, a, b) ||
             id_out !== id || res_label !== (l_a | l_b)) begin
            n_fail++;
            $display("FAIL random[%0d]: op=%0d a=%h b=%h lat=%0d res=%h id=%0d lbl=%b, want lat=%0d res=%h id=%0d lbl=%b",
                     i, op, a, b, lat, res, id_out, res_label,
                     ref_lat(a, b, l_a, l_b), ref_mul(op, a, b), id, l_a | l_b);
         end
         consume();
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
      int           lat;
      int           bad;
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      exp = ref_mul(2'd3, a, b);
      issue(2'd3, a, b, 1'b0, 1'b1, 3'd6);
      wait_result(lat);
      n_tests++;
      if (lat != LAT || res !== exp) begin
         n_fail++;
         $display("FAIL bp_first: lat=%0d res=%h, want lat=%0d res=%h", lat, res, LAT, exp);
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_vld !== 1'b1 || res !== exp || id_out !== 3'd6 ||
             res_label !== 1'b1 || in_rdy !== 1'b0) begin
            bad++;
         end
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL bp_hold: %0d unstable cycles, want 0 (last vld=%b res=%h id=%0d rdy=%b)",
                  bad, out_vld, res, id_out, in_rdy);
      end
      consume();
      n_tests++;
      if (in_rdy !== 1'b1 || out_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_release: rdy=%b vld=%b, want 1 0", in_rdy, out_vld);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           lat;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      issue(2'd1, 64'd9, 64'd11, 1'b0, 1'b0, 3'd1);
      wait_result(lat);
      n_tests++;
      if (lat != LAT || res !== 64'd0) begin
         n_fail++;
         $display("FAIL b2b_first: lat=%0d res=%h, want lat=%0d res=0", lat, res, LAT);
      end
      // The next request is already waiting while the result is consumed.
      out_rdy = 1'b1;
      opcode = 2'd2; op_a = a; op_b = b; la = 1'b0; lb = 1'b0; id_in = 3'd4;
      in_vld = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_rdy = 1'b0;
      n_tests++;
      if (out_vld !== 1'b0 || in_rdy !== 1'b0 || state !== 2'd0) begin
         n_fail++;
         $display("FAIL b2b_idle: vld=%b rdy=%b state=%0d, want 0 0 0", out_vld, in_rdy, state);
      end
      @(posedge clk);
      @(negedge clk);
      in_vld = 1'b0;
      wait_result(lat);
      n_tests++;
      if (lat != LAT || res !== ref_mul(2'd2, a, b) || id_out !== 3'd4) begin
         n_fail++;
         $display("FAIL b2b_second: lat=%0d res=%h id=%0d, want lat=%0d res=%h id=4",
                  lat, res, id_out, LAT, ref_mul(2'd2, a, b));
      end
      consume();
   endtask

   task automatic test_flush();
      int lat;
      int seen;
      issue(2'd0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0, 3'd5);
      repeat (19) @(negedge clk);
      // Falling edge inside cycle T0+20. A request raised together with the
      // flush must be ignored.
      flush = 1'b1;
      in_vld = 1'b1;
      opcode = 2'd0; op_a = 64'd1; op_b = 64'd1; id_in = 3'd7;
      #1;
      n_tests++;
      if (out_vld !== 1'b0 || in_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_mask: vld=%b rdy=%b, want 0 0", out_vld, in_rdy);
      end
      @(negedge clk);
      flush = 1'b0;
      in_vld = 1'b0;
      #1;
      n_tests++;
      if (in_rdy !== 1'b1 || state !== 2'd0) begin
         n_fail++;
         $display("FAIL flush_idle: rdy=%b state=%0d, want 1 0", in_rdy, state);
      end
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (out_vld === 1'b1) seen++;
      end
      n_tests++;
      if (seen != 0) begin
         n_fail++;
         $display("FAIL flush_no_result: out_vld seen %0d cycles, want 0", seen);
      end
      issue(2'd3, 64'd2, 64'd3, 1'b0, 1'b0, 3'd6);
      wait_result(lat);
      n_tests++;
      if (lat != LAT || res !== 64'd0 || id_out !== 3'd6) begin
         n_fail++;
         $display("FAIL flush_next: lat=%0d res=%h id=%0d, want lat=%0d res=0 id=6",
                  lat, res, id_out, LAT);
      end
      consume();
   endtask

   task automatic test_reset_mid();
      int seen;
      issue(2'd0, 64'd12345, 64'd678, 1'b1, 1'b0, 3'd7);
      repeat (30) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (out_vld !== 1'b0 || in_rdy !== 1'b1 || id_out !== '0 ||
          res !== '0 || res_label !== 1'b0 || state !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_mid: vld=%b rdy=%b id=%0d res=%h lbl=%b state=%0d, want 0 1 0 0 0 0",
                  out_vld, in_rdy, id_out, res, res_label, state);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (out_vld === 1'b1) seen++;
      end
      n_tests++;
      if (seen != 0) begin
         n_fail++;
         $display("FAIL reset_mid_no_result: out_vld seen %0d cycles, want 0", seen);
      end
   endtask

   initial begin
      rst_n = 1'b0; in_vld = 1'b0; out_rdy = 1'b0; flush = 1'b0;
      id_in = '0; op_a = '0; op_b = '0; opcode = 2'd0; la = 1'b0; lb = 1'b0;
      test_reset();
      test_directed();
      test_zero();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
